// File: rtl/fifo_arb_pkg.sv
// Shared types and default sizing for the FIFO read-port arbiter.
package fifo_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_e;

  localparam int unsigned DEF_NREQ       = 4;
  localparam int unsigned DEF_DATA_WIDTH = 32;
  localparam int unsigned DEF_MAX_BURST  = 4;

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin picker: first set request at or above rr_ptr, with wrap.
module rr_priority_picker
  import fifo_arb_pkg::*;
#(
  parameter int unsigned NREQ     = DEF_NREQ,
  parameter int unsigned ID_WIDTH = $clog2(NREQ)
) (
  input  logic [NREQ-1:0]     req,
  input  logic [ID_WIDTH-1:0] rr_ptr,
  output logic [ID_WIDTH-1:0] winner_c,
  output logic                any_req_c
);

  logic        found;
  int unsigned idx;

  // Scan all requesters starting from rr_ptr; the first hit wins.
  always_comb begin
    winner_c  = '0;
    found     = 1'b0;
    idx       = 0;
    any_req_c = |req;
    for (int unsigned i = 0; i < NREQ; i++) begin
      idx = 32'(rr_ptr) + i;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!found && req[idx[ID_WIDTH-1:0]]) begin
        found    = 1'b1;
        winner_c = ID_WIDTH'(idx);
      end
    end
  end

endmodule

// File: rtl/fifo_read_arbiter.sv
// Round-robin burst arbiter sharing one FWFT FIFO read port among NREQ consumers.
module fifo_read_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int unsigned NREQ       = DEF_NREQ,
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned MAX_BURST  = DEF_MAX_BURST,
  parameter int unsigned ID_WIDTH   = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req,
  output logic [NREQ-1:0]       gnt,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_rdata,
  output logic                  fifo_ren,
  output logic                  resp_val,
  input  logic                  resp_rdy,
  output logic [DATA_WIDTH-1:0] resp_data,
  output logic [ID_WIDTH-1:0]   resp_id
);

  localparam int unsigned BEAT_W = $clog2(MAX_BURST + 1);

  state_e                state_q, state_d;
  logic [ID_WIDTH-1:0]   owner_q, owner_d;
  logic [ID_WIDTH-1:0]   rr_ptr_q, rr_ptr_d;
  logic [BEAT_W-1:0]     beats_q, beats_d;
  logic                  resp_val_q, resp_val_d;
  logic [DATA_WIDTH-1:0] resp_data_q, resp_data_d;
  logic [ID_WIDTH-1:0]   resp_id_q, resp_id_d;

  logic [ID_WIDTH-1:0]   winner_c;
  logic                  any_req_c;
  logic                  pop_c;
  logic [BEAT_W-1:0]     beats_inc_c;
  logic                  burst_done_c;

  rr_priority_picker #(
    .NREQ     (NREQ),
    .ID_WIDTH (ID_WIDTH)
  ) u_picker (
    .req       (req),
    .rr_ptr    (rr_ptr_q),
    .winner_c  (winner_c),
    .any_req_c (any_req_c)
  );

  // Pop only while the owner still wants data, the FIFO has a word and the response slot can take it.
  always_comb begin
    pop_c        = (state_q == BURST) && req[owner_q] && !fifo_empty && (!resp_val_q || resp_rdy);
    beats_inc_c  = beats_q + BEAT_W'(1);
    burst_done_c = (pop_c && (beats_inc_c == BEAT_W'(MAX_BURST))) || !req[owner_q] || fifo_empty;
  end

  // One-hot grant follows the owner while bursting.
  always_comb begin
    gnt = '0;
    if (state_q == BURST) gnt[owner_q] = 1'b1;
  end

  assign fifo_ren  = pop_c;
  assign resp_val  = resp_val_q;
  assign resp_data = resp_data_q;
  assign resp_id   = resp_id_q;

  // Next-state for FSM, beat counter, round-robin pointer and response slot.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    rr_ptr_d    = rr_ptr_q;
    beats_d     = beats_q;
    resp_val_d  = resp_val_q;
    resp_data_d = resp_data_q;
    resp_id_d   = resp_id_q;

    if (pop_c) begin
      resp_val_d  = 1'b1;
      resp_data_d = fifo_rdata;
      resp_id_d   = owner_q;
      beats_d     = beats_inc_c;
    end else if (resp_rdy) begin
      resp_val_d = 1'b0;
    end

    unique case (state_q)
      IDLE: begin
        if (any_req_c && !fifo_empty) begin
          state_d = BURST;
          owner_d = winner_c;
          beats_d = '0;
        end
      end
      BURST: begin
        if (burst_done_c) begin
          state_d  = IDLE;
          rr_ptr_d = (owner_q == ID_WIDTH'(NREQ - 1)) ? '0 : owner_q + ID_WIDTH'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      owner_q     <= '0;
      rr_ptr_q    <= '0;
      beats_q     <= '0;
      resp_val_q  <= 1'b0;
      resp_data_q <= '0;
      resp_id_q   <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      rr_ptr_q    <= rr_ptr_d;
      beats_q     <= beats_d;
      resp_val_q  <= resp_val_d;
      resp_data_q <= resp_data_d;
      resp_id_q   <= resp_id_d;
    end
  end

endmodule
